exec_wb_stage: RTL and testbench

Multi-cycle execute/writeback stage directly upstream of the 4x8 register file.
- Accepts one decoded instruction through a valid/ready handshake.
- Drives the register file's two read channels (N1/N2) and samples Q1/Q2.
- Computes an 8-bit result plus carry/zero flags.
- Writes the result back through the register file's write channel (ND/DI/REG_WE).

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/alu8.sv | 69 ++++++
 rtl/exec_wb_stage.sv | 199 +++++++++++++++++++
 tb/tb_exec_wb_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute/writeback stage and its ALU:
// data width, opcode encodings, FSM state encoding and a flag-update
// helper.
package cpu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPRD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Single-cycle ops that update C/Z. MOV, LDI and the NOP opcodes leave
  // the flags alone. MUL updates flags through its own sequencing path.
  function automatic logic op_sets_flags(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_CMP: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU that covers every single-cycle opcode.
// Ports:
//   op     in   opcode
//   a, b   in   operands latched from the register file
//   imm    in   immediate operand (LDI)
//   cin    in   current carry flag (ADC)
//   result out  8-bit result, modulo 256
//   cout   out  carry, or borrow for SUB/CMP
//   zero   out  result == 0
//   wb_en  out  the op writes its result back
module alu8
  import cpu_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic          cout,
  output logic          zero,
  output logic          wb_en
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    cout   = 1'b0;
    wb_en  = 1'b1;
    case (op)
      OP_MOV: result = b;
      OP_LDI: result = imm;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        cout   = sum[DW];
      end
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        result = sum[DW-1:0];
        cout   = sum[DW];
      end
      // The 9-bit difference borrows into bit DW exactly when a < b.
      OP_SUB, OP_CMP: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0];
        cout   = sum[DW];
        wb_en  = (op != OP_CMP);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        cout   = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        cout   = a[0];
      end
      // MUL is sequenced by the stage. C..F are NOPs.
      default: wb_en = 1'b0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Multi-cycle execute/writeback stage that sits in front of a 4x8
// register file.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   IN_VALID/IN_READY    instruction handshake (ready only in IDLE)
//   OPC, RA, RB, RD, IMM decoded instruction fields
//   N1, N2 / Q1, Q2      register file read ids (out) / read data (in)
//   ND, DI, REG_WE       register file write channel
//   FLAG_C, FLAG_Z       carry/borrow and zero flags
//   BUSY                 inverse of IN_READY
//
// state  | meaning
// IDLE   | ready; accept instruction, drive N1/N2
// OPRD   | sample Q1/Q2 into A/B
// EXEC   | single-cycle ALU op, or 8 MUL shift-add steps
// WB     | REG_WE high, ND/DI hold the result
module exec_wb_stage
  import cpu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [3:0]    OPC,
  input  logic [1:0]    RA,
  input  logic [1:0]    RB,
  input  logic [1:0]    RD,
  input  logic [DW-1:0] IMM,
  output logic [1:0]    N1,
  output logic [1:0]    N2,
  input  logic [DW-1:0] Q1,
  input  logic [DW-1:0] Q2,
  output logic [1:0]    ND,
  output logic [DW-1:0] DI,
  output logic          REG_WE,
  output logic          FLAG_C,
  output logic          FLAG_Z,
  output logic          BUSY
);

  state_t          state_q, state_d;
  logic [3:0]      opc_q, opc_d;
  logic [1:0]      rd_q, rd_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic [1:0]      n1_q, n1_d;
  logic [1:0]      n2_q, n2_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      nd_q, nd_d;
  logic [DW-1:0]   di_q, di_d;
  logic            reg_we_q, reg_we_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;

  logic [DW-1:0]   alu_result;
  logic            alu_cout;
  logic            alu_zero;
  logic            alu_wb_en;
  logic            is_mul;
  logic [2*DW-1:0] mul_addend;
  logic [2*DW-1:0] prod_step;

  alu8 u_alu (
    .op     (opc_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .cin    (flag_c_q),
    .result (alu_result),
    .cout   (alu_cout),
    .zero   (alu_zero),
    .wb_en  (alu_wb_en)
  );

  assign is_mul = MUL_EN && (opc_q == OP_MUL);

  // Iteration cnt_q adds A shifted by cnt_q when multiplier bit cnt_q is set.
  assign mul_addend = b_q[cnt_q] ? ({{DW{1'b0}}, a_q} << cnt_q) : '0;
  assign prod_step  = prod_q + mul_addend;

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    nd_d     = nd_q;
    di_d     = di_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          opc_d   = OPC;
          rd_d    = RD;
          imm_d   = IMM;
          n1_d    = RA;
          n2_d    = RB;
          state_d = S_OPRD;
        end
      end
      S_OPRD: begin
        a_d     = Q1;
        b_d     = Q2;
        prod_d  = '0;
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_mul) begin
          prod_d = prod_step;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            flag_c_d = |prod_step[2*DW-1:DW];
            flag_z_d = (prod_step[DW-1:0] == '0);
            nd_d     = rd_q;
            di_d     = prod_step[DW-1:0];
            state_d  = S_WB;
          end
        end else begin
          if (op_sets_flags(opc_q)) begin
            flag_c_d = alu_cout;
            flag_z_d = alu_zero;
          end
          if (alu_wb_en) begin
            nd_d    = rd_q;
            di_d    = alu_result;
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Write enable comes straight from a flop so the register file never
    // sees a decode glitch.
    reg_we_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      nd_q     <= '0;
      di_q     <= '0;
      reg_we_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      nd_q     <= nd_d;
      di_q     <= di_d;
      reg_we_q <= reg_we_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign IN_READY = (state_q == S_IDLE);
  assign BUSY     = ~IN_READY;
  assign N1       = n1_q;
  assign N2       = n2_q;
  assign ND       = nd_q;
  assign DI       = di_q;
  assign REG_WE   = reg_we_q;
  assign FLAG_C   = flag_c_q;
  assign FLAG_Z   = flag_z_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
module tb_exec_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [3:0] OPC = '0;
  logic [1:0] RA = '0, RB = '0, RD = '0;
  logic [7:0] IMM = '0;
  logic       IN_READY, BUSY, REG_WE, FLAG_C, FLAG_Z;
  logic [1:0] N1, N2, ND;
  logic [7:0] Q1, Q2, DI;

  // Second instance built without the multiplier.
  logic       in_valid_x = 1'b0;
  logic       in_ready_x, busy_x, reg_we_x, flag_c_x, flag_z_x;
  logic [1:0] n1_x, n2_x, nd_x;
  logic [7:0] di_x;

  logic [7:0] rf [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         we_cnt = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign Q1 = rf[N1];
  assign Q2 = rf[N2];

  always @(posedge clk) begin
    if (REG_WE) begin
      rf[ND] <= DI;
      we_cnt <= we_cnt + 1;
    end
  end

  exec_wb_stage #(.MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPC(OPC), .RA(RA), .RB(RB), .RD(RD), .IMM(IMM),
    .N1(N1), .N2(N2), .Q1(Q1), .Q2(Q2),
    .ND(ND), .DI(DI), .REG_WE(REG_WE),
    .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z), .BUSY(BUSY)
  );

  exec_wb_stage #(.MUL_EN(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid_x), .IN_READY(in_ready_x),
    .OPC(OPC), .RA(RA), .RB(RB), .RD(RD), .IMM(IMM),
    .N1(n1_x), .N2(n2_x), .Q1(8'h10), .Q2(8'h11),
    .ND(nd_x), .DI(di_x), .REG_WE(reg_we_x),
    .FLAG_C(flag_c_x), .FLAG_Z(flag_z_x), .BUSY(busy_x)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction to dut (sel=0) or dut_x (sel=1) and watch the
  // 12 cycles after the accept edge. exp_we_k = 0 means no writeback.
  task automatic run(input string tag, input bit sel, input logic [3:0] op,
                     input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                     input logic [7:0] imm, input int exp_we_k, input int exp_rdy_k,
                     input logic [1:0] exp_nd, input logic [7:0] exp_di);
    int we_k, we_n, rdy_k;
    logic [1:0] nd_s;
    logic [7:0] di_s;
    we_k = 0; we_n = 0; rdy_k = 0; nd_s = '0; di_s = '0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? in_ready_x : IN_READY) break;
      @(negedge clk);
    end
    chk({tag, "_ready_wait"}, {15'd0, sel ? in_ready_x : IN_READY}, 16'd1);
    OPC = op; RA = ra; RB = rb; RD = rd; IMM = imm;
    if (sel) in_valid_x = 1'b1; else IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
    in_valid_x = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sel ? reg_we_x : REG_WE) begin
        we_n++;
        if (we_k == 0) begin
          we_k = k;
          nd_s = sel ? nd_x : ND;
          di_s = sel ? di_x : DI;
        end
      end
      if ((sel ? in_ready_x : IN_READY) && rdy_k == 0) rdy_k = k;
    end
    chk({tag, "_we_cycle"}, 16'(we_k), 16'(exp_we_k));
    chk({tag, "_we_count"}, 16'(we_n), (exp_we_k != 0) ? 16'd1 : 16'd0);
    chk({tag, "_ready_cycle"}, 16'(rdy_k), 16'(exp_rdy_k));
    if (exp_we_k != 0) begin
      chk({tag, "_nd"}, {14'd0, nd_s}, {14'd0, exp_nd});
      chk({tag, "_di"}, {8'd0, di_s}, {8'd0, exp_di});
    end
  endtask

  task automatic flags(input string tag, input bit sel, input logic c, input logic z);
    chk({tag, "_c"}, {15'd0, sel ? flag_c_x : FLAG_C}, {15'd0, c});
    chk({tag, "_z"}, {15'd0, sel ? flag_z_x : FLAG_Z}, {15'd0, z});
  endtask

  initial begin
    int we_before;
    logic [3:0] q_op [0:2];
    logic [1:0] q_ra [0:2], q_rb [0:2], q_rd [0:2];
    logic [7:0] q_imm [0:2];
    int acc [0:2];
    int idx;
    logic rdy, add_c, add_z, add_seen;

    // Reset state
    #12;
    chk("rst_ready", {15'd0, IN_READY}, 16'd1);
    chk("rst_busy", {15'd0, BUSY}, 16'd0);
    chk("rst_outs", {N1, N2, ND, REG_WE, FLAG_C, FLAG_Z}, 16'd0);
    chk("rst_di", {8'd0, DI}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of a MUL
    run("ldi_r1_10", 0, 4'h1, 2'd0, 2'd0, 2'd1, 8'h10, 3, 4, 2'd1, 8'h10);
    run("ldi_r2_11", 0, 4'h1, 2'd0, 2'd0, 2'd2, 8'h11, 3, 4, 2'd2, 8'h11);
    OPC = 4'hA; RA = 2'd1; RB = 2'd2; RD = 2'd3; IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
    repeat (5) @(negedge clk);
    we_before = we_cnt;
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_ready", {15'd0, IN_READY}, 16'd1);
    chk("midmul_rst_we", {15'd0, REG_WE}, 16'd0);
    chk("midmul_rst_outs", {N1, N2, ND, FLAG_C, FLAG_Z}, 16'd0);
    chk("midmul_rst_di", {8'd0, DI}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midmul_no_write", 16'(we_cnt), 16'(we_before));
    chk("midmul_r3", {8'd0, rf[3]}, 16'h0000);

    // 2: LDI, LDI, ADD with carry out
    run("ldi_r1_f0", 0, 4'h1, 2'd0, 2'd0, 2'd1, 8'hF0, 3, 4, 2'd1, 8'hF0);
    run("ldi_r2_20", 0, 4'h1, 2'd0, 2'd0, 2'd2, 8'h20, 3, 4, 2'd2, 8'h20);
    run("add_r3", 0, 4'h2, 2'd1, 2'd2, 2'd3, 8'h00, 3, 4, 2'd3, 8'h10);
    flags("add_r3", 0, 1'b1, 1'b0);
    chk("add_r3_rf", {8'd0, rf[3]}, 16'h0010);

    // 3: SUB with borrow, CMP equal
    run("sub_r0", 0, 4'h4, 2'd2, 2'd1, 2'd0, 8'h00, 3, 4, 2'd0, 8'h30);
    flags("sub_r0", 0, 1'b1, 1'b0);
    run("cmp_r1", 0, 4'hB, 2'd1, 2'd1, 2'd2, 8'h00, 0, 3, 2'd0, 8'h00);
    flags("cmp_r1", 0, 1'b0, 1'b1);
    chk("cmp_rf", {rf[1], rf[2]}, 16'hF020);

    // 4: MUL and the MUL-disabled variant
    run("ldi_r1_10b", 0, 4'h1, 2'd0, 2'd0, 2'd1, 8'h10, 3, 4, 2'd1, 8'h10);
    run("ldi_r2_11b", 0, 4'h1, 2'd0, 2'd0, 2'd2, 8'h11, 3, 4, 2'd2, 8'h11);
    run("mul_r3", 0, 4'hA, 2'd1, 2'd2, 2'd3, 8'h00, 10, 11, 2'd3, 8'h10);
    flags("mul_r3", 0, 1'b1, 1'b0);
    chk("mul_r3_rf", {8'd0, rf[3]}, 16'h0010);
    run("x_sub", 1, 4'h4, 2'd0, 2'd1, 2'd2, 8'h00, 3, 4, 2'd2, 8'hFF);
    flags("x_sub", 1, 1'b1, 1'b0);
    run("x_mul_nop", 1, 4'hA, 2'd0, 2'd1, 2'd2, 8'h00, 0, 3, 2'd0, 8'h00);
    flags("x_mul_nop", 1, 1'b1, 1'b0);

    // 5: ADC after carry, SHR, MOV, XOR
    run("ldi_r0_ff", 0, 4'h1, 2'd0, 2'd0, 2'd0, 8'hFF, 3, 4, 2'd0, 8'hFF);
    run("ldi_r1_01", 0, 4'h1, 2'd0, 2'd0, 2'd1, 8'h01, 3, 4, 2'd1, 8'h01);
    run("add_wrap", 0, 4'h2, 2'd0, 2'd1, 2'd2, 8'h00, 3, 4, 2'd2, 8'h00);
    flags("add_wrap", 0, 1'b1, 1'b1);
    run("adc_r3", 0, 4'h3, 2'd1, 2'd1, 2'd3, 8'h00, 3, 4, 2'd3, 8'h03);
    flags("adc_r3", 0, 1'b0, 1'b0);
    run("shr_r2", 0, 4'h9, 2'd1, 2'd0, 2'd2, 8'h00, 3, 4, 2'd2, 8'h00);
    flags("shr_r2", 0, 1'b1, 1'b1);
    run("mov_r0", 0, 4'h0, 2'd0, 2'd3, 2'd0, 8'h00, 3, 4, 2'd0, 8'h03);
    flags("mov_r0", 0, 1'b1, 1'b1);
    run("xor_r3", 0, 4'h7, 2'd0, 2'd1, 2'd3, 8'h00, 3, 4, 2'd3, 8'h02);
    flags("xor_r3", 0, 1'b0, 1'b0);

    // 6: IN_VALID held across three back-to-back instructions
    run("ldi_r1_80", 0, 4'h1, 2'd0, 2'd0, 2'd1, 8'h80, 3, 4, 2'd1, 8'h80);
    q_op[0] = 4'h2; q_ra[0] = 2'd1; q_rb[0] = 2'd1; q_rd[0] = 2'd1; q_imm[0] = 8'h00;
    q_op[1] = 4'h1; q_ra[1] = 2'd0; q_rb[1] = 2'd0; q_rd[1] = 2'd2; q_imm[1] = 8'h55;
    q_op[2] = 4'h6; q_ra[2] = 2'd2; q_rb[2] = 2'd1; q_rd[2] = 2'd3; q_imm[2] = 8'h00;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    idx = 0; add_c = 1'b0; add_z = 1'b0; add_seen = 1'b0;
    we_before = we_cnt;
    for (int it = 0; it < 20; it++) begin
      if (idx < 3) begin
        OPC = q_op[idx]; RA = q_ra[idx]; RB = q_rb[idx]; RD = q_rd[idx]; IMM = q_imm[idx];
        IN_VALID = 1'b1;
      end else begin
        IN_VALID = 1'b0;
      end
      if (REG_WE && ND == 2'd1) begin
        add_c = FLAG_C; add_z = FLAG_Z; add_seen = 1'b1;
      end
      rdy = IN_READY;
      @(posedge clk);
      if (rdy && idx < 3) begin
        acc[idx] = it;
        idx++;
      end
      @(negedge clk);
    end
    IN_VALID = 1'b0;
    chk("b2b_accepts", 16'(idx), 16'd3);
    chk("b2b_gap01", 16'(acc[1] - acc[0]), 16'd4);
    chk("b2b_gap12", 16'(acc[2] - acc[1]), 16'd4);
    chk("b2b_writes", 16'(we_cnt - we_before), 16'd3);
    chk("b2b_add_flags", {13'd0, add_seen, add_c, add_z}, 16'h0007);
    chk("b2b_r1", {8'd0, rf[1]}, 16'h0000);
    chk("b2b_r2_r3", {rf[2], rf[3]}, 16'h5555);
    flags("b2b_or", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
